// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of requester A/B handshakes and the shared RAM word port
// slave modport  : arbiter side (takes requests, drives acks/rdata/rvalid and the RAM port)
// master modport : requesters + RAM side
//   a_req/a_addr -> a_ack/a_rdata/a_rvalid            requester A (read-only)
//   b_req/b_we/b_be/b_addr/b_wdata -> b_ack/b_rdata/b_rvalid  requester B (load/store)
//   mem_addr/mem_wdata/mem_we -> mem_rdata            RAM port, combinational read

interface mem_port_arbiter_if;
  logic        a_req;
  logic [31:0] a_addr;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        a_rvalid;

  logic        b_req;
  logic        b_we;
  logic [3:0]  b_be;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_rvalid;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  a_req, a_addr,
    input  b_req, b_we, b_be, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, a_rvalid,
    output b_ack, b_rdata, b_rvalid,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output a_req, a_addr,
    output b_req, b_we, b_be, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, a_rvalid,
    input  b_ack, b_rdata, b_rvalid,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for one word-wide RAM port with RMW partial stores
// m_clock : clock, rising edge
// p_reset : asynchronous active-high reset
// bus     : mem_port_arbiter_if.slave (requester A, requester B, RAM port)
// FIXED_PRIO : 0 = round-robin on ties, 1 = A always wins ties

module mem_port_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  m_clock,
  input  logic                  p_reset,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] old_q, old_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;

  logic        grant_a, grant_b;
  logic [31:0] mem_addr_c, mem_wdata_c;
  logic        mem_we_c;
  logic [31:0] merge_w;
  logic [31:0] word_addr;

  // Low address bits are dropped here rather than at latch time so the whole
  // request address is carried and only the RAM sees the aligned word address.
  assign word_addr = addr_q & 32'hFFFF_FFFC;

  always_comb begin
    merge_w = '0;
    for (int i = 0; i < 4; i++) begin
      merge_w[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.mem_rdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    old_d        = old_q;
    merged_d     = merged_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    mem_addr_c   = 32'h0;
    mem_wdata_c  = 32'h0;
    mem_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie A wins when fixed priority is set or B was served last.
        grant_a = bus.a_req &&
                  (!bus.b_req || (FIXED_PRIO != 0) || (last_grant_q == OWN_B));
        grant_b = bus.b_req && !grant_a;
        if (grant_a) begin
          addr_d       = bus.a_addr;
          we_d         = 1'b0;
          be_d         = 4'h0;
          wdata_d      = 32'h0;
          owner_d      = OWN_A;
          last_grant_d = OWN_A;
          state_d      = XFER;
        end else if (grant_b) begin
          addr_d       = bus.b_addr;
          we_d         = bus.b_we;
          be_d         = bus.b_be;
          wdata_d      = bus.b_wdata;
          owner_d      = OWN_B;
          last_grant_d = OWN_B;
          state_d      = XFER;
        end
      end

      XFER: begin
        mem_addr_c = word_addr;
        if (!we_q || (be_q == 4'h0)) begin
          // Loads, and stores with no lanes enabled, are plain reads.
          if (owner_q == OWN_A) begin
            a_rdata_d  = bus.mem_rdata;
            a_rvalid_d = 1'b1;
          end else begin
            b_rdata_d  = bus.mem_rdata;
            b_rvalid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (be_q == 4'hF) begin
          // Full-word store writes directly; the read in the same cycle
          // still returns the pre-store word.
          mem_we_c    = 1'b1;
          mem_wdata_c = wdata_q;
          b_rdata_d   = bus.mem_rdata;
          b_rvalid_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          // Partial store: keep the old word for b_rdata and write the merge next cycle.
          old_d    = bus.mem_rdata;
          merged_d = merge_w;
          state_d  = WRITE;
        end
      end

      WRITE: begin
        mem_addr_c  = word_addr;
        mem_we_c    = 1'b1;
        mem_wdata_c = merged_q;
        // b_rdata only changes on completion, so the old word is published here.
        b_rdata_d   = old_q;
        b_rvalid_d  = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
      old_q        <= 32'h0;
      merged_q     <= 32'h0;
      a_rdata_q    <= 32'h0;
      b_rdata_q    <= 32'h0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      old_q        <= old_d;
      merged_q     <= merged_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
    end
  end

  // Acks are combinational from req, so they are masked while reset is held.
  assign bus.a_ack     = grant_a & ~p_reset;
  assign bus.b_ack     = grant_b & ~p_reset;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table plus scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic m_clock = 1'b0;
  logic p_reset;
  always #5 m_clock = ~m_clock;

  mem_port_arbiter_if bus0 ();
  mem_port_arbiter_if bus1 ();

  mem_port_arbiter #(.FIXED_PRIO(0)) dut0 (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus0)
  );

  mem_port_arbiter #(.FIXED_PRIO(1)) dut1 (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus1)
  );

  logic [31:0] ram [0:255];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  assign bus0.mem_rdata = ram[bus0.mem_addr[9:2]];
  assign bus1.mem_rdata = 32'h0;

  always @(posedge m_clock) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    else if (bus0.mem_we) ram[bus0.mem_addr[9:2]] <= bus0.mem_wdata;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } sb_t;
  sb_t sbq[$];

  // Expected read data is the bench RAM word at acceptance time (pre-store word for stores).
  always @(negedge m_clock) begin
    sb_t e;
    if (!p_reset) begin
      if (bus0.a_ack) sbq.push_back('{1'b0, ram[bus0.a_addr[9:2]]});
      if (bus0.b_ack) sbq.push_back('{1'b1, ram[bus0.b_addr[9:2]]});
      if (bus0.a_rvalid || bus0.b_rvalid) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_rvalid", 32'h1, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("sb_port", {31'b0, bus0.b_rvalid}, {31'b0, e.port});
          chk("sb_rdata", e.port ? bus0.b_rdata : bus0.a_rdata, e.rdata);
        end
      end
    end
  end

  typedef struct {
    logic        is_b;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] old;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs[8];

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(posedge m_clock); #1;
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge m_clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic        acked;
    int          lat, nwr, bad;
    logic [31:0] wd, rd;
    acked = 1'b0; lat = 0; nwr = 0; bad = 0; wd = 32'h0; rd = 32'h0;
    preload(v.addr[9:2], v.old);
    if (v.is_b) begin
      bus0.b_req = 1'b1; bus0.b_we = v.we; bus0.b_be = v.be;
      bus0.b_addr = v.addr; bus0.b_wdata = v.wdata;
    end else begin
      bus0.a_req = 1'b1; bus0.a_addr = v.addr;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge m_clock);
      if (v.is_b ? bus0.b_ack : bus0.a_ack) begin
        acked = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_ack", k), {31'b0, acked}, 32'h1);
    @(posedge m_clock); #1;
    bus0.a_req = 1'b0; bus0.b_req = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge m_clock);
      if (cyc == 1) chk($sformatf("v%0d_mem_addr", k), bus0.mem_addr, v.addr & 32'hFFFF_FFFC);
      if (bus0.mem_we) begin
        nwr++; wd = bus0.mem_wdata;
      end else if (bus0.mem_wdata != 32'h0) begin
        bad++;
      end
      if (v.is_b ? bus0.b_rvalid : bus0.a_rvalid) begin
        lat = cyc;
        rd = v.is_b ? bus0.b_rdata : bus0.a_rdata;
        break;
      end
    end
    chk($sformatf("v%0d_latency", k), lat, v.exp_lat);
    chk($sformatf("v%0d_writes", k), nwr, v.exp_nwr);
    if (v.exp_nwr != 0) chk($sformatf("v%0d_wdata", k), wd, v.exp_wdata);
    chk($sformatf("v%0d_wdata_idle", k), bad, 0);
    chk($sformatf("v%0d_rdata", k), rd, v.exp_rdata);
    chk($sformatf("v%0d_ram", k), ram[v.addr[9:2]], v.exp_final);
  endtask

  int ga, gb, g;
  logic acked;

  initial begin
    p_reset = 1'b1;
    pre_en = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
    bus0.a_req = 1'b0; bus0.a_addr = 32'h0;
    bus0.b_req = 1'b0; bus0.b_we = 1'b0; bus0.b_be = 4'h0; bus0.b_addr = 32'h0; bus0.b_wdata = 32'h0;
    bus1.a_req = 1'b0; bus1.a_addr = 32'h0;
    bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_be = 4'h0; bus1.b_addr = 32'h0; bus1.b_wdata = 32'h0;

    //            is_b  we    be     addr           wdata          old            exp_rdata      lat nwr exp_wdata      exp_final
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 0, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 4'h5, 32'h0000_0023, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 3, 1, 32'h11BB_33DD, 32'h11BB_33DD};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF, 32'h55AA_55AA, 32'h55AA_55AA, 2, 0, 32'h0,         32'h55AA_55AA};
    vecs[4] = '{1'b1, 1'b1, 4'h0, 32'h0000_0044, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0102_0304, 2, 0, 32'h0,         32'h0102_0304};
    vecs[5] = '{1'b1, 1'b1, 4'h8, 32'h0000_0080, 32'h9988_7766, 32'h0000_0000, 32'h0000_0000, 3, 1, 32'h9900_0000, 32'h9900_0000};
    vecs[6] = '{1'b1, 1'b1, 4'h6, 32'h0000_03FE, 32'h00AB_CD00, 32'h1234_5678, 32'h1234_5678, 3, 1, 32'h12AB_CD78, 32'h12AB_CD78};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 2, 0, 32'h0,         32'hA5A5_A5A5};

    // Reset state, with a pending A request that must not be acked.
    bus0.a_req = 1'b1;
    #12;
    chk("rst_a_ack", {31'b0, bus0.a_ack}, 32'h0);
    chk("rst_mem_we", {31'b0, bus0.mem_we}, 32'h0);
    chk("rst_mem_addr", bus0.mem_addr, 32'h0);
    chk("rst_rvalid", {30'b0, bus0.a_rvalid, bus0.b_rvalid}, 32'h0);
    chk("rst_a_rdata", bus0.a_rdata, 32'h0);
    chk("rst_b_rdata", bus0.b_rdata, 32'h0);
    bus0.a_req = 1'b0;
    @(posedge m_clock); #1;
    p_reset = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);
    chk("hold_a_rdata", bus0.a_rdata, 32'hA5A5_A5A5);
    chk("hold_b_rdata", bus0.b_rdata, 32'h1234_5678);

    // Reset asserted while a partial store sits in WRITE.
    preload(8'h30, 32'h0F0F_0F0F);
    bus0.b_req = 1'b1; bus0.b_we = 1'b1; bus0.b_be = 4'h3;
    bus0.b_addr = 32'h0000_00C1; bus0.b_wdata = 32'hFFFF_FFFF;
    acked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge m_clock);
      if (bus0.b_ack) begin acked = 1'b1; break; end
    end
    chk("rw_ack", {31'b0, acked}, 32'h1);
    @(posedge m_clock); #1;
    bus0.b_req = 1'b0;
    @(negedge m_clock);
    chk("rw_xfer_we", {31'b0, bus0.mem_we}, 32'h0);
    @(negedge m_clock);
    chk("rw_write_we", {31'b0, bus0.mem_we}, 32'h1);
    #1 p_reset = 1'b1;
    #1;
    chk("rw_rst_we", {31'b0, bus0.mem_we}, 32'h0);
    chk("rw_rst_wdata", bus0.mem_wdata, 32'h0);
    chk("rw_rst_addr", bus0.mem_addr, 32'h0);
    sbq.delete();
    @(posedge m_clock); #1;
    p_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge m_clock);
      chk("rw_no_rvalid", {31'b0, bus0.b_rvalid}, 32'h0);
    end
    chk("rw_b_rdata", bus0.b_rdata, 32'h0);
    chk("rw_ram_intact", ram[8'h30], 32'h0F0F_0F0F);

    // Round-robin with both requesting: A first after reset, then alternate.
    preload(8'h40, 32'h1111_1111);
    preload(8'h41, 32'h2222_2222);
    bus0.a_req = 1'b1; bus0.a_addr = 32'h0000_0100;
    bus0.b_req = 1'b1; bus0.b_we = 1'b0; bus0.b_be = 4'h0; bus0.b_addr = 32'h0000_0104;
    g = 0;
    for (int i = 0; i < 40 && g < 6; i++) begin
      @(negedge m_clock);
      if (bus0.a_ack && bus0.b_ack) chk("rr_both_ack", 32'h1, 32'h0);
      if (bus0.a_ack || bus0.b_ack) begin
        chk($sformatf("rr_grant%0d", g), {31'b0, bus0.b_ack}, g % 2);
        g++;
      end
    end
    chk("rr_count", g, 6);
    @(posedge m_clock); #1;
    bus0.a_req = 1'b0; bus0.b_req = 1'b0;
    repeat (4) @(negedge m_clock);

    // Fixed priority: B never granted while A is held.
    @(posedge m_clock); #1;
    bus1.a_req = 1'b1; bus1.a_addr = 32'h0000_0200;
    bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 32'h0000_0204;
    ga = 0; gb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge m_clock);
      if (bus1.a_ack) ga++;
      if (bus1.b_ack) gb++;
    end
    chk("fp_a_grants", ga, 6);
    chk("fp_b_grants", gb, 0);
    @(posedge m_clock); #1;
    bus1.a_req = 1'b0; bus1.b_req = 1'b0;
    repeat (4) @(negedge m_clock);

    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
